initmem_writer: RTL
===================

Name: initmem_writer

Overview:
- Sits directly downstream of the SD-card file loader during the boot-time memory-init phase.
- Consumes 32-bit words that the loader presents with a held write-enable, handshaking through an 8-bit controller state (0 = ready).
- Buffers the words in a small FIFO and commits them to the memory controller as sequential word writes from BASE_ADDR.
- Counts and checksums committed words, flags protocol errors, and raises done once the whole image is in memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- BIN_SIZE, 32'd4096, image size in bytes; a multiple of 4; expected word count N = BIN_SIZE/4.
- FIFO_DEPTH, 4, word FIFO depth; a power of 2, at least 2.

Ports:
- clk27mhz  in  1  single system clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_data  in  32  word from the loader, valid while s_we=1.
- s_we  in  1  loader write-enable, held high until ctrl_state is nonzero.
- s_done  in  1  loader finished; permits early completion.
- ctrl_state  out  8  handshake state to the loader: 0=IDLE, 1=CAPTURE, 2=WAIT_LOW, 3=FULL, 4=DONE.
- m_req  out  1  memory write request.
- m_addr  out  32  byte address.
- m_wdata  out  32  write data.
- m_be  out  4  byte enables, constant 4'hF.
- m_ack  in  1  memory accepted the request.
- wr_count  out  32  number of words committed (acked).
- checksum  out  32  sum of committed words, mod 2^32.
- done  out  1  image fully committed; sticky until reset.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset, asynchronous: ctrl_state=0, FIFO empty, push count=0, m_req=0, m_addr=0, m_wdata=0, wr_count=0, checksum=0, done=0, overflow=0. An in-flight request is dropped immediately.
- Loader side state machine; transitions on clock edges only:
  - IDLE(0), s_we=1: push s_data into FIFO, push count +1, go CAPTURE.
  - IDLE(0), s_we=1 and push count already = N: do not push, set overflow, go CAPTURE.
  - CAPTURE(1): go WAIT_LOW unconditionally. This guarantees one push per s_we assertion.
  - WAIT_LOW(2): stay while s_we=1. When s_we=0, go FULL if the FIFO is full, else IDLE.
  - FULL(3): go IDLE on the first cycle the FIFO has a free slot. s_we=1 here is held off, not lost.
  - DONE(4): terminal. Any s_we=1 sets overflow; data is dropped.
- Memory side runs concurrently with the loader side:
  - When m_req=0 and the FIFO is non-empty: next edge m_req=1, m_wdata=head, m_addr=BASE_ADDR+(wr_count<<2), and the head is popped.
  - m_req, m_addr and m_wdata are held stable until m_ack=1 is sampled.
  - On the ack edge: m_req=0, wr_count+1, checksum += m_wdata.
  - At least one m_req=0 cycle separates consecutive requests.
  - m_ack while m_req=0 is ignored.
- Simultaneous push and pop in one cycle is legal. FIFO occupancy is unchanged and FULL is not entered.
- Completion: done goes to 1 on the edge after all of the following hold together: FIFO empty, m_req=0, wr_count=N or s_done=1, and the state machine is in IDLE or FULL. ctrl_state becomes 4 on the same edge.
- Early s_done (wr_count<N) still completes; the short image is reported only through wr_count.
- Address arithmetic is 32-bit and wraps silently. wr_count never exceeds N.

Test Plan:
- Nominal: BIN_SIZE=16, loader model pushes 32'h11111111, 22222222, 33333333, 44444444, m_ack one cycle after each request → writes land at BASE+0/4/8/C in order; wr_count=4; checksum=32'hAAAAAAAA; done=1; ctrl_state=4; overflow=0.
- Backpressure: m_ack held low for 50 cycles while the loader keeps pushing → ctrl_state reaches 3 after 4 buffered words, no word lost or duplicated, m_addr/m_wdata stable while waiting; after m_ack resumes, all words land and done=1.
- Long s_we: s_we held high for 10 cycles on one word → exactly one push, ctrl_state sequence 0→1→2(×9)→0.
- Overrun: after done=1, pulse s_we with 32'hDEADBEEF → overflow=1, no m_req, wr_count unchanged.
- Early finish: BIN_SIZE=16, only 2 words pushed then s_done=1 → done=1 after both are acked, wr_count=2.
- Async reset: assert resetn=0 mid-request, between clock edges → m_req=0 and all outputs cleared before the next edge; a fresh image then loads correctly from BASE_ADDR.

Source files
------------

// File: rtl/initmem_writer.sv
`default_nettype none
// ============================================================================
// Module   : initmem_writer
// Purpose  : Boot-time memory-init writer. Accepts words from the SD-card
//            loader through a held write-enable / state handshake, buffers
//            them in a small FIFO and commits them as sequential word writes
//            starting at BASE_ADDR. Tracks committed count and checksum,
//            flags overruns and reports completion.
// Revision : 1.0  initial release
// ============================================================================
module initmem_writer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] BIN_SIZE   = 32'd4096,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk27mhz,
  input  logic        resetn,
  input  logic [31:0] s_data,
  input  logic        s_we,
  input  logic        s_done,
  output logic [7:0]  ctrl_state,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  output logic [31:0] wr_count,
  output logic [31:0] checksum,
  output logic        done,
  output logic        overflow
);

  // Expected number of words in the image.
  localparam logic [31:0] WORDS = BIN_SIZE >> 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Loader handshake states; the encoding is what the loader sees.
  typedef enum logic [7:0] {
    ST_IDLE     = 8'd0,
    ST_CAPTURE  = 8'd1,
    ST_WAIT_LOW = 8'd2,
    ST_FULL     = 8'd3,
    ST_DONE     = 8'd4
  } state_t;

  state_t           state;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [31:0]      push_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic complete;
  logic push;
  logic pop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);

  // Everything is in memory (or the loader gave up early) and the loader
  // is not in the middle of a handshake.
  assign complete = fifo_empty && !m_req &&
                    ((wr_count == WORDS) || s_done) &&
                    ((state == ST_IDLE) || (state == ST_FULL));

  // A word is accepted only from IDLE, once per s_we assertion, and never
  // beyond the image size. Completion takes priority over a new push.
  assign push = (state == ST_IDLE) && !complete && s_we && (push_cnt != WORDS);

  // A new request is launched only from an idle memory port, which also
  // guarantees a gap cycle between consecutive requests.
  assign pop = !m_req && !fifo_empty;

  assign ctrl_state = state;
  assign m_be       = 4'hF;

  // Loader-side handshake FSM with push accounting and sticky flags.
  always_ff @(posedge clk27mhz or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      push_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (complete) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (s_we) begin
            state <= ST_CAPTURE;
            if (push_cnt == WORDS) begin
              overflow <= 1'b1;
            end else begin
              push_cnt <= push_cnt + 32'd1;
            end
          end
        end
        ST_CAPTURE: begin
          state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!s_we) begin
            state <= fifo_full ? ST_FULL : ST_IDLE;
          end
        end
        ST_FULL: begin
          if (complete) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (!fifo_full) begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (s_we) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked.
  always_ff @(posedge clk27mhz) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers/occupancy and the memory-side request/commit logic.
  always_ff @(posedge clk27mhz or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      m_req    <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      wr_count <= '0;
      checksum <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (pop) begin
        m_req   <= 1'b1;
        m_wdata <= fifo_mem[rd_ptr];
        m_addr  <= BASE_ADDR + (wr_count << 2);
      end else if (m_req && m_ack) begin
        m_req    <= 1'b0;
        wr_count <= wr_count + 32'd1;
        checksum <= checksum + m_wdata;
      end
    end
  end

endmodule
`default_nettype wire
